// File: rtl/sa_result_drain_if.sv
// Wishbone slave bus bundle for sa_result_drain.
//   wb_stb_i/wb_cyc_i/wb_we_i : strobe, cycle, write enable (master -> slave)
//   wb_sel_i                  : byte select, not used by the slave
//   wb_adr_i/wb_dat_i         : address and write data (master -> slave)
//   wb_ack_o/wb_dat_o         : registered acknowledge and read data (slave -> master)
interface sa_result_drain_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/sa_result_drain.sv
// Collects a 3x3 result tile from a skewed 3-column systolic array over five
// beats, quantises it (ReLU, arithmetic shift, 8-bit saturation) one element
// per cycle, then exposes the nine bytes as three Wishbone-readable words.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid            : one pulse per array beat
//   out1, out2, out3    : signed column outputs
//   in_ready            : high while collecting
//   res_ready           : high while a quantised tile is available
//   bus                 : Wishbone slave (data word at BASE_ADDRESS, status at +4)
module sa_result_drain #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0010,
  parameter int unsigned OUT_SHIFT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] out1,
  input  logic signed [15:0] out2,
  input  logic signed [15:0] out3,
  output logic               in_ready,
  output logic               res_ready,
  sa_result_drain_if.slave   bus
);

  localparam logic [31:0] STAT_ADDRESS = BASE_ADDRESS + 32'd4;
  localparam int unsigned N_ELEM       = 9;

  typedef enum logic [1:0] {COLLECT, QUANT, READY} state_t;

  state_t             state, state_next;
  logic [2:0]         b;
  logic [3:0]         q;
  logic [1:0]         r;
  logic               ovf;
  logic signed [15:0] raw      [N_ELEM];
  logic [7:0]         res_byte [N_ELEM];

  logic        hit_data_c, hit_stat_c, bus_req_c;
  logic        abort_c, data_rd_c, stat_rd_c, ovf_set_c;
  logic [31:0] rd_word_c;
  logic        unused_c;

  // Byte select and upper write-data bits carry no meaning here.
  assign unused_c = ^{bus.wb_sel_i, bus.wb_dat_i[31:1]};

  // Bus decode; a request is taken only when no ack is pending.
  assign hit_data_c = (bus.wb_adr_i == BASE_ADDRESS);
  assign hit_stat_c = (bus.wb_adr_i == STAT_ADDRESS);
  assign bus_req_c  = bus.wb_stb_i && bus.wb_cyc_i && !bus.wb_ack_o && (hit_data_c || hit_stat_c);
  assign abort_c    = bus_req_c && bus.wb_we_i && hit_stat_c && bus.wb_dat_i[0];
  assign data_rd_c  = bus_req_c && !bus.wb_we_i && hit_data_c && (state == READY);
  assign stat_rd_c  = bus_req_c && !bus.wb_we_i && hit_stat_c;
  // A beat outside COLLECT is dropped and flagged, unless an abort swallows it.
  assign ovf_set_c  = in_valid && (state != COLLECT) && !abort_c;

  // ReLU, arithmetic shift, saturate to 8 bits.
  function automatic logic [7:0] quant(input logic signed [15:0] v);
    logic signed [15:0] s;
    logic [7:0]         res;
    s = v >>> OUT_SHIFT;
    if (v[15])                res = 8'd0;
    else if (s > 16'sd255)    res = 8'hFF;
    else                      res = s[7:0];
    return res;
  endfunction

  // Read data mux; writes return zero.
  always_comb begin
    rd_word_c = '0;
    if (!bus.wb_we_i) begin
      if (hit_stat_c) begin
        rd_word_c = {26'b0, r, 2'b0, ovf, res_ready};
      end else if (state == READY) begin
        case (r)
          2'd0:    rd_word_c = {res_byte[3], res_byte[2], res_byte[1], res_byte[0]};
          2'd1:    rd_word_c = {res_byte[7], res_byte[6], res_byte[5], res_byte[4]};
          2'd2:    rd_word_c = {24'b0, res_byte[8]};
          default: rd_word_c = '0;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (in_valid && b == 3'd4)        state_next = QUANT;
      QUANT:   if (q == 4'd8)                    state_next = READY;
      READY:   if (data_rd_c && r == 2'd2)       state_next = COLLECT;
      default:                                   state_next = COLLECT;
    endcase
    if (abort_c) state_next = COLLECT;
  end

  // Datapath, counters, bus response and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      b            <= '0;
      q            <= '0;
      r            <= '0;
      ovf          <= 1'b0;
      raw          <= '{default: '0};
      res_byte     <= '{default: '0};
      in_ready     <= 1'b1;
      res_ready    <= 1'b0;
      bus.wb_ack_o <= 1'b0;
      bus.wb_dat_o <= '0;
    end else begin
      in_ready     <= (state_next == COLLECT);
      res_ready    <= (state_next == READY);
      bus.wb_ack_o <= bus_req_c;
      if (bus_req_c) bus.wb_dat_o <= rd_word_c;

      if (ovf_set_c)      ovf <= 1'b1;
      else if (stat_rd_c) ovf <= 1'b0;

      if (abort_c) begin
        b        <= '0;
        q        <= '0;
        r        <= '0;
        raw      <= '{default: '0};
        res_byte <= '{default: '0};
      end else begin
        case (state)
          COLLECT: if (in_valid) begin
            // Column k's element j appears on beat k+j (skewed array output).
            if (b <= 3'd2)                raw[4'(b)]         <= out1;
            if (b >= 3'd1 && b <= 3'd3)   raw[4'(b) + 4'd2]  <= out2;
            if (b >= 3'd2)                raw[4'(b) + 4'd4]  <= out3;
            b <= (b == 3'd4) ? 3'd0 : b + 3'd1;
          end
          QUANT: begin
            res_byte[q] <= quant(raw[q]);
            q           <= (q == 4'd8) ? 4'd0 : q + 4'd1;
          end
          READY: if (data_rd_c) begin
            if (r == 2'd2) begin
              r   <= '0;
              raw <= '{default: '0};
            end else begin
              r <= r + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed/randomised bench for sa_result_drain with a tile-level reference model.
module tb_sa_result_drain;

  localparam logic [31:0] BASE = 32'h3000_0010;
  localparam logic [31:0] STAT = BASE + 32'd4;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] out1, out2, out3;
  logic               in_ready, res_ready;

  sa_result_drain_if bus ();

  sa_result_drain #(.BASE_ADDRESS(BASE), .OUT_SHIFT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .in_ready  (in_ready),
    .res_ready (res_ready),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] f1 [5];
  logic [15:0] f2 [5];
  logic [15:0] f3 [5];
  logic [31:0] exp_w [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference quantiser: clamp negatives, divide by 2^4, clamp to 255.
  function automatic logic [7:0] model_q(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = 0;
    s = s / 16;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  // Element i belongs to column i/3, row i%3, delivered on beat column+row.
  task automatic build_expect();
    logic [7:0] e [9];
    for (int i = 0; i < 9; i++) begin
      int col;
      int bt;
      col = i / 3;
      bt  = col + (i % 3);
      if (col == 0)      e[i] = model_q(f1[bt]);
      else if (col == 1) e[i] = model_q(f2[bt]);
      else               e[i] = model_q(f3[bt]);
    end
    exp_w[0] = {e[3], e[2], e[1], e[0]};
    exp_w[1] = {e[7], e[6], e[5], e[4]};
    exp_w[2] = {24'b0, e[8]};
  endtask

  task automatic fill_const(input logic [15:0] a, input logic [15:0] b2, input logic [15:0] c);
    for (int i = 0; i < 5; i++) begin
      f1[i] = a; f2[i] = b2; f3[i] = c;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 5; i++) begin
      f1[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 5000)) : 16'($urandom);
      f2[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 5000)) : 16'($urandom);
      f3[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 5000)) : 16'($urandom);
    end
  endtask

  // Sends five back-to-back beats, optionally one stray beat during quantisation,
  // and returns the number of cycles until res_ready (0 if it never came).
  task automatic send_frame(input bit stray, output int lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      out1 = f1[i]; out2 = f2[i]; out3 = f3[i];
      tick();
    end
    in_valid = 1'b0;
    build_expect();
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 1 && stray) begin
        in_valid = 1'b1;
        out1 = 16'($urandom); out2 = 16'($urandom); out3 = 16'($urandom);
      end
      tick();
      in_valid = 1'b0;
      if (res_ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output bit acked);
    bus.wb_adr_i = a; bus.wb_we_i = 1'b0; bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
    acked = 1'b0;
    d     = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.wb_ack_o) begin
        acked = 1'b1;
        d     = bus.wb_dat_o;
        break;
      end
    end
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
    tick();
  endtask

  task automatic wb_write(input string tag, input logic [31:0] a, input logic [31:0] d, input bit iv);
    bit acked;
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_we_i = 1'b1;
    bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
    in_valid = iv;
    acked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid = 1'b0;
      if (bus.wb_ack_o) begin
        acked = 1'b1;
        break;
      end
    end
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    tick();
    check({tag, "_ack"}, 32'(acked), 32'd1);
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bit          acked;
    wb_read(a, d, acked);
    check({tag, "_ack"}, 32'(acked), 32'd1);
    check(tag, d, exp);
  endtask

  task automatic read_frame(input string tag);
    read_check({tag, "_w0"}, BASE, exp_w[0]);
    read_check({tag, "_w1"}, BASE, exp_w[1]);
    read_check({tag, "_w2"}, BASE, exp_w[2]);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks;
    int b2b;
    bit prev_ack;
    logic [31:0] burst_d [2];

    rst = 1'b1; in_valid = 1'b0; out1 = '0; out2 = '0; out3 = '0;
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 4'hF; bus.wb_adr_i = '0; bus.wb_dat_i = '0;
    repeat (3) tick();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_ready", 32'(res_ready), 32'd0);
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    rst = 1'b0;
    tick();
    read_check("rst_status", STAT, 32'h0);
    read_check("idle_data", BASE, 32'h0);

    // Constant 0x0123 frame: latency and packing
    fill_const(16'h0123, 16'h0123, 16'h0123);
    send_frame(1'b0, lat);
    check("const_latency", 32'(lat), 32'd9);
    read_check("const_w0", BASE, 32'h1212_1212);
    read_check("const_w1", BASE, 32'h1212_1212);
    read_check("const_w2", BASE, 32'h0000_0012);
    check("const_in_ready", 32'(in_ready), 32'd1);

    // Saturation and ReLU
    fill_const(16'h7FFF, 16'h8000, 16'h000F);
    send_frame(1'b0, lat);
    check("sat_latency", 32'(lat), 32'd9);
    read_check("sat_w0", BASE, 32'h00FF_FFFF);
    read_check("sat_w1", BASE, 32'h0000_0000);
    read_check("sat_w2", BASE, 32'h0000_0000);

    // Random frames against the model
    for (int n = 0; n < 4; n++) begin
      fill_rand();
      send_frame(1'b0, lat);
      check("rand_latency", 32'(lat), 32'd9);
      read_frame("rand");
    end

    // Overflow: stray beat during quantisation
    fill_rand();
    send_frame(1'b1, lat);
    check("ovf_latency", 32'(lat), 32'd9);
    read_check("ovf_status1", STAT, 32'h0000_0003);
    read_check("ovf_status2", STAT, 32'h0000_0001);
    read_frame("ovf");

    // Abort after one data read, with a coincident beat
    fill_rand();
    send_frame(1'b0, lat);
    read_check("abort_w0", BASE, exp_w[0]);
    read_check("abort_pre_status", STAT, 32'h0000_0011);
    wb_write("abort_wr", STAT, 32'h0000_0001, 1'b1);
    read_check("abort_status", STAT, 32'h0);
    read_check("abort_data", BASE, 32'h0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    fill_rand();
    send_frame(1'b0, lat);
    check("abort_new_latency", 32'(lat), 32'd9);
    read_frame("abort_new");

    // Reset mid-read, then a partial frame wiped by reset
    fill_rand();
    send_frame(1'b0, lat);
    read_check("rstmid_w0", BASE, exp_w[0]);
    rst = 1'b1;
    tick();
    check("rstmid_dat", bus.wb_dat_o, 32'd0);
    check("rstmid_res_ready", 32'(res_ready), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; out1 = 16'($urandom); out2 = 16'($urandom); out3 = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    fill_const(16'h0040, 16'h0040, 16'h0040);
    send_frame(1'b0, lat);
    check("rstmid_latency", 32'(lat), 32'd9);
    read_check("rstmid_new_w0", BASE, 32'h0404_0404);
    read_check("rstmid_new_w1", BASE, 32'h0404_0404);
    read_check("rstmid_new_w2", BASE, 32'h0000_0004);

    // Unmapped address never acknowledged
    acks = 0;
    bus.wb_adr_i = BASE + 32'd8; bus.wb_we_i = 1'b0; bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.wb_ack_o) acks++;
    end
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
    tick();
    check("unmapped_acks", 32'(acks), 32'd0);

    // Held strobe: isolated acks, one read index step per ack
    fill_rand();
    send_frame(1'b0, lat);
    acks = 0; b2b = 0; prev_ack = 1'b0;
    burst_d[0] = '0; burst_d[1] = '0;
    bus.wb_adr_i = BASE; bus.wb_we_i = 1'b0; bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.wb_ack_o) begin
        if (prev_ack) b2b++;
        if (acks < 2) burst_d[acks] = bus.wb_dat_o;
        acks++;
      end
      prev_ack = bus.wb_ack_o;
    end
    bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
    tick();
    check("burst_acks", 32'(acks), 32'd2);
    check("burst_b2b", 32'(b2b), 32'd0);
    check("burst_d0", burst_d[0], exp_w[0]);
    check("burst_d1", burst_d[1], exp_w[1]);
    check("burst_dat_hold", bus.wb_dat_o, exp_w[1]);
    wb_write("ignored_wr_data", BASE, 32'hFFFF_FFFF, 1'b0);
    wb_write("ignored_wr_stat", STAT, 32'h0000_0000, 1'b0);
    read_check("burst_status", STAT, 32'h0000_0021);
    read_check("burst_w2", BASE, exp_w[2]);
    check("burst_in_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_result_drain.md
SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h3000_0010, the data-word address; status word is at BASE_ADDRESS+4.
REQ-002 SHALL have parameter OUT_SHIFT, default 4, the arithmetic right shift applied before saturation.
REQ-003 SHALL have ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  one pulse per systolic-array beat
- out1, out2, out3  in  16 each  array column outputs, signed two's complement
- in_ready  out  1  high only in COLLECT
- res_ready  out  1  high only in READY (interrupt-style level)
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone strobe, cycle, write enable
- wb_sel_i  in  4  byte select, ignored
- wb_adr_i  in  32  address
- wb_dat_i  in  32  write data
- wb_ack_o  out  1  registered acknowledge
- wb_dat_o  out  32  registered read data

Function
REQ-004 SHALL use three states: COLLECT, QUANT, READY.
REQ-005 COLLECT: beat counter b (0..4) SHALL advance on each in_valid.
- out1 SHALL be captured into raw[b] for b=0..2.
- out2 SHALL be captured into raw[3+b-1] for b=1..3.
- out3 SHALL be captured into raw[6+b-2] for b=2..4.
- On the in_valid at b=4, state SHALL go to QUANT and b SHALL return to 0.
REQ-006 QUANT: one element per cycle, index q=0..8, then go to READY the cycle after q=8. Fixed latency of 9 cycles from the last in_valid to res_ready.
REQ-007 Per element: negative values SHALL become 0 (ReLU); then arithmetic shift right by OUT_SHIFT; then saturate to 8 bits, so values above 255 SHALL become 255. Result stored in byte q[7:0].
REQ-008 READY, data reads SHALL return packed bytes {byte[3],byte[2],byte[1],byte[0]}, then {byte[7..4]}, then {24'b0, byte[8]}, selected by read index r (0..2). Each acked data read SHALL increment r.
- After the read at r=2 is acked: r SHALL return to 0, state SHALL go to COLLECT, raw buffers SHALL be cleared.
REQ-009 Data reads outside READY SHALL return 0 and SHALL NOT change r.
REQ-010 Status read SHALL return {26'b0, r[1:0], 2'b0, ovf, res_ready}.
REQ-011 ovf is a sticky bit, set when in_valid arrives outside COLLECT; that beat SHALL be dropped.
- An acked status read SHALL clear ovf.
- If set and clear coincide, set SHALL win.
REQ-012 Write to the status address with wb_dat_i[0]=1 SHALL abort from any state: state to COLLECT, b=0, q=0, r=0, raw and byte buffers to 0. ovf is unchanged.
REQ-013 All other writes SHALL be acknowledged and ignored.
REQ-014 Acknowledge:
- wb_ack_o SHALL assert for exactly one cycle, one cycle after wb_stb_i && wb_cyc_i && !wb_ack_o with an address equal to either decoded address.
- Other addresses SHALL never be acknowledged.
- Side effects (r increment, ovf clear, abort) SHALL occur once, on the acknowledged cycle.
REQ-015 wb_dat_o SHALL be loaded in the same cycle that wb_ack_o is set, and SHALL hold its value otherwise.
REQ-016 If in_valid coincides with an abort write, the abort SHALL win and the beat SHALL be dropped without setting ovf.

Reset
REQ-017 On rst the block SHALL:
- enter COLLECT;
- set b, q, r, ovf, raw[], byte[] to 0;
- set wb_ack_o=0, wb_dat_o=0, res_ready=0, in_ready=1.
REQ-018 rst asserted mid-frame or mid-read SHALL discard all partial data with no output side effects; the first in_valid after rst deasserts is beat 0.

Verification
REQ-019 Full frame with all outputs=0x0123, then 3 data reads:
- res_ready rises 9 cycles after the 5th in_valid;
- reads return 0x1212_1212, 0x1212_1212, 0x0000_0012;
- in_ready is 1 afterwards.
REQ-020 Saturation/ReLU: out1=0x7FFF, out2=0x8000, out3=0x000F over a frame -> bytes 0-2=0xFF, 3-5=0x00, 6-8=0x00; reads return 0x00FF_FFFF, 0x0000_0000, 0x0000_0000.
REQ-021 Overflow: in_valid during QUANT -> status bit1=1 on the next status read; a second status read returns bit1=0; frame data is unaffected.
REQ-022 Abort: write 0x1 to BASE+4 in READY after one data read -> status reads 0x0, data read returns 0, a new frame is captured correctly.
REQ-023 Reset mid-read: rst after the first data read -> wb_dat_o=0, res_ready=0; a following frame of 0x0040 values reads 0x0404_0404 from word 0.
REQ-024 Bus: strobe to BASE+8 gets no ack; stb held high for 4 cycles on BASE -> ack pulses are never back-to-back, and r advances once per ack.
